pipeline_control_arbiter: RTL and testbench
===========================================

# pipeline_control_arbiter

Merges the `lc3b_pipeline_control_word` requests from all pipeline controllers into the single control word that drives the IF/ID/EX/MEM/WB stages and barriers. Requesters include the branch controller, the hazard/forwarding unit, the cache-miss controller and trap/interrupt sequencing. Non-exclusive requests are OR-merged each cycle. An exclusive request locks the pipeline to one owner until that owner releases it, and a watchdog force-releases the lock on timeout. The block sits between the controllers and the pipeline top-level and also keeps a stall-cycle performance counter.

## Interface
- `NUM_REQ`, 4: number of requesters; index 0 has the highest priority.
- `MAX_LOCK_CYCLES`, 64: maximum number of consecutive cycles a single exclusive lock may be held.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input `NUM_REQ` x `lc3b_pipeline_control_word`: per-requester control request.
- `pipeline_control_out` output `lc3b_pipeline_control_word`: merged control word, combinational.
- `owner_onehot` output `NUM_REQ`: current lock owner; all zero when unlocked.
- `locked` output 1: high while in the LOCKED state.
- `lock_timeout` output 1: one-cycle pulse when the watchdog forces a release.
- `exclusive_conflict` output 1: high when more than one eligible exclusive request is present in IDLE.
- `stall_cycle_count` output 32: count of cycles with any stage or barrier stall asserted in `pipeline_control_out`; saturates at 0xFFFFFFFF.

## Operation
- Eligible exclusive request: `req[i].active && req[i].exclusive && !excl_mask[i]`.
- FSM has two states: IDLE and LOCKED. The state register resets to IDLE.
- IDLE:
  - No eligible exclusive request: output is the merge of all active requests. Merge rules:
    - every `*_stall`, `*_reset` and `force_sr*_load` field is the OR over active requesters;
    - `active` is the OR of all `active` bits;
    - `exclusive` is 0 in the output.
  - Eligible exclusive requests present: the lowest index wins and its word passes through unmodified in that same cycle. Next state is LOCKED, the owner is registered, and `lock_cnt` loads 1.
- LOCKED:
  - While `req[owner].active` is high: output is `req[owner]` only, and all other requests are ignored. `lock_cnt` increments.
  - Owner drops `active` or `exclusive`: output is the IDLE merge of the remaining requests, with exclusive bits ignored this cycle. Next state is IDLE.
  - `lock_cnt == MAX_LOCK_CYCLES` with the owner still active:
    - output that cycle is still the owner's word;
    - `lock_timeout` pulses;
    - next state is IDLE;
    - `excl_mask[owner]` is set.
- `excl_mask[i]` clears on the first cycle in which `req[i].active` is low. While it is set, requester i is merged as non-exclusive.
- Reset dominance: in the merged output, if `barrier_X_reset` is 1 then `barrier_X_stall` is forced to 0.
- The `stall_cycle_count` increment condition is computed from the final `pipeline_control_out`.

## Timing
- `pipeline_control_out` has zero latency from `req` and is purely combinational from `req` and registered state.
- Lock takes effect in the same cycle the exclusive request appears. `owner_onehot` and `locked` are registered and assert the following cycle.
- A requester may hold exclusive ownership for at most `MAX_LOCK_CYCLES` consecutive output cycles.
- Reset values, applied asynchronously on `rst_n` low:
  - state IDLE, `owner_onehot` 0, `locked` 0, `lock_timeout` 0;
  - `lock_cnt` 0, `excl_mask` 0, `stall_cycle_count` 0;
  - `pipeline_control_out` equals the merge of the current `req` inputs.
- Reset mid-lock: ownership is dropped immediately, and the next exclusive request re-arbitrates from IDLE.
- A release and a new exclusive request from another requester in the same cycle: the new request is not granted until the following cycle, because exclusive bits are ignored during the release cycle.
- `exclusive_conflict` is combinational and valid only in IDLE; it is 0 in LOCKED.

## Structure
- Shared package `lc3b_types` holds:
  - `lc3b_arb_state` enum {`arb_idle`, `arb_locked`};
  - the existing `lc3b_pipeline_control_word`.
- One sub-module, `pipeline_control_merge`: combinational OR-merge of N control words with reset-over-stall dominance, taking a per-requester enable vector.

## Test plan
- req[1] active with `barrier_IF_ID_reset`=1, and req[2] active with `stage_IF_stall`=1 and `barrier_IF_ID_stall`=1 -> output: IF_ID_reset=1, IF_ID_stall=0, IF_stall=1, active=1; `locked` stays 0.
- req[2] exclusive with `stage_ID_stall`=1 for 5 cycles while req[0] requests `barrier_EX_MEM_reset` -> output shows only ID stall for 5 cycles; `locked`=1 during cycles 2-5; the cycle after req[2] drops, output shows EX_MEM_reset.
- req[1] and req[3] exclusive in the same cycle -> req[1] owns, `exclusive_conflict`=1 for that cycle, `owner_onehot`=4'b0010 the next cycle.
- req[0] exclusive held for 70 cycles with `MAX_LOCK_CYCLES`=64 -> `lock_timeout` pulses on cycle 64; from cycle 65 req[0] is merged as non-exclusive until it drops `active`.
- `rst_n` pulsed low mid-lock -> `locked`=0, `owner_onehot`=0 and `stall_cycle_count`=0 immediately, without waiting for a clock edge.
- Stall asserted for 10 cycles with the counter preloaded near its maximum -> count advances by exactly 10, then sticks at 0xFFFFFFFF once saturated.

Source files
------------

// File: rtl/pipeline_control_arbiter_pkg.sv
// Shared LC-3b pipeline control types: arbiter state and the per-stage control word.
package lc3b_types;

    typedef enum logic {
        arb_idle,
        arb_locked
    } lc3b_arb_state;

    typedef struct packed {
        logic active;
        logic exclusive;
        logic stage_IF_stall;
        logic stage_ID_stall;
        logic stage_EX_stall;
        logic stage_MEM_stall;
        logic stage_WB_stall;
        logic barrier_IF_ID_stall;
        logic barrier_ID_EX_stall;
        logic barrier_EX_MEM_stall;
        logic barrier_MEM_WB_stall;
        logic barrier_IF_ID_reset;
        logic barrier_ID_EX_reset;
        logic barrier_EX_MEM_reset;
        logic barrier_MEM_WB_reset;
        logic force_sr1_load;
        logic force_sr2_load;
    } lc3b_pipeline_control_word;

    // True when any stage or barrier is being held this cycle.
    function automatic logic ctrl_stall_any(input lc3b_pipeline_control_word w);
        return w.stage_IF_stall | w.stage_ID_stall | w.stage_EX_stall |
               w.stage_MEM_stall | w.stage_WB_stall |
               w.barrier_IF_ID_stall | w.barrier_ID_EX_stall |
               w.barrier_EX_MEM_stall | w.barrier_MEM_WB_stall;
    endfunction

endpackage

// File: rtl/pipeline_control_arbiter_merge.sv
// OR-merge of enabled control words; a barrier reset overrides that barrier's stall.
module pipeline_control_merge
    import lc3b_types::*;
#(
    parameter int unsigned N = 4
) (
    input  lc3b_pipeline_control_word req_i [N],
    input  logic [N-1:0]              en_i,
    output lc3b_pipeline_control_word merged_o
);

    lc3b_pipeline_control_word acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en_i[i]) begin
                acc = lc3b_pipeline_control_word'(acc | req_i[i]);
            end
        end
        acc.exclusive = 1'b0;
        if (acc.barrier_IF_ID_reset)  acc.barrier_IF_ID_stall  = 1'b0;
        if (acc.barrier_ID_EX_reset)  acc.barrier_ID_EX_stall  = 1'b0;
        if (acc.barrier_EX_MEM_reset) acc.barrier_EX_MEM_stall = 1'b0;
        if (acc.barrier_MEM_WB_reset) acc.barrier_MEM_WB_stall = 1'b0;
    end

    assign merged_o = acc;

endmodule

// File: rtl/pipeline_control_arbiter.sv
// Arbitrates pipeline controller requests: OR-merge by default, exclusive locking
// with a watchdog, and a saturating stall-cycle counter.
module pipeline_control_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_LOCK_CYCLES = 64,
    parameter logic [31:0] STALL_CNT_RESET = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  lc3b_pipeline_control_word req [NUM_REQ],
    output lc3b_pipeline_control_word pipeline_control_out,
    output logic [NUM_REQ-1:0]        owner_onehot,
    output logic                      locked,
    output logic                      lock_timeout,
    output logic                      exclusive_conflict,
    output logic [31:0]               stall_cycle_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LOCK_CYCLES + 1);

    lc3b_arb_state             state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [NUM_REQ-1:0]        onehot_q, onehot_d;
    logic [CNT_W-1:0]          lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]        mask_q, mask_d;
    logic [31:0]               stall_cnt_q, stall_cnt_d;

    logic [NUM_REQ-1:0]        active_vec, eligible;
    logic [IDX_W-1:0]          winner;
    lc3b_pipeline_control_word merged, ctrl_out;
    logic                      timeout_c, conflict_c;

    always_comb begin
        active_vec = '0;
        eligible   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            active_vec[i] = req[i].active;
            eligible[i]   = req[i].active & req[i].exclusive & ~mask_q[i];
        end
    end

    // Lowest index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDX_W'(i);
        end
    end

    pipeline_control_merge #(.N(NUM_REQ)) u_merge (
        .req_i    (req),
        .en_i     (active_vec),
        .merged_o (merged)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        onehot_d   = onehot_q;
        lock_cnt_d = lock_cnt_q;
        ctrl_out   = merged;
        timeout_c  = 1'b0;
        conflict_c = 1'b0;
        case (state_q)
            arb_idle: begin
                conflict_c = (eligible & (eligible - NUM_REQ'(1))) != '0;
                if (eligible != '0) begin
                    ctrl_out   = req[winner];
                    state_d    = arb_locked;
                    owner_d    = winner;
                    onehot_d   = NUM_REQ'(1) << winner;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            arb_locked: begin
                if (req[owner_q].active && req[owner_q].exclusive) begin
                    ctrl_out = req[owner_q];
                    // lock_cnt_q counts owned cycles already completed; this one is the last allowed.
                    if (lock_cnt_q >= CNT_W'(MAX_LOCK_CYCLES - 1)) begin
                        timeout_c  = 1'b1;
                        state_d    = arb_idle;
                        onehot_d   = '0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = arb_idle;
                    onehot_d   = '0;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = arb_idle;
        endcase
    end

    // A timed-out owner stays non-exclusive until it drops active.
    always_comb begin
        mask_d = (mask_q & active_vec) | (timeout_c ? onehot_q : '0);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl_stall_any(ctrl_out) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= arb_idle;
            owner_q     <= '0;
            onehot_q    <= '0;
            lock_cnt_q  <= '0;
            mask_q      <= '0;
            stall_cnt_q <= STALL_CNT_RESET;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            onehot_q    <= onehot_d;
            lock_cnt_q  <= lock_cnt_d;
            mask_q      <= mask_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pipeline_control_out = ctrl_out;
    assign owner_onehot         = onehot_q;
    assign locked               = (state_q == arb_locked);
    assign lock_timeout         = timeout_c;
    assign exclusive_conflict   = conflict_c;
    assign stall_cycle_count    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Directed bench for pipeline_control_arbiter: merge, locking, watchdog, reset and counter.
module tb_pipeline_control_arbiter;
    import lc3b_types::*;

    logic clk;
    logic rst_n;
    lc3b_pipeline_control_word req     [4];
    lc3b_pipeline_control_word req_sat [4];

    lc3b_pipeline_control_word out, out_s;
    logic [3:0]  onehot, onehot_s;
    logic        locked, locked_s, tmo, tmo_s, conf, conf_s;
    logic [31:0] cnt, cnt_s;

    int tests_run;
    int tests_failed;

    pipeline_control_arbiter #(.NUM_REQ(4), .MAX_LOCK_CYCLES(64)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .pipeline_control_out (out),
        .owner_onehot         (onehot),
        .locked               (locked),
        .lock_timeout         (tmo),
        .exclusive_conflict   (conf),
        .stall_cycle_count    (cnt)
    );

    pipeline_control_arbiter #(.NUM_REQ(4), .MAX_LOCK_CYCLES(64),
                               .STALL_CNT_RESET(32'hFFFF_FFF0)) dut_sat (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req_sat),
        .pipeline_control_out (out_s),
        .owner_onehot         (onehot_s),
        .locked               (locked_s),
        .lock_timeout         (tmo_s),
        .exclusive_conflict   (conf_s),
        .stall_cycle_count    (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_req();
        for (int i = 0; i < 4; i++) req[i] = '0;
    endtask

    task automatic clr_sat();
        for (int i = 0; i < 4; i++) req_sat[i] = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        lc3b_pipeline_control_word w0, w1, w2, w3, e;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clr_req();
        clr_sat();

        // Reset state and combinational merge during reset
        #2;
        w3 = '0; w3.active = 1'b1; w3.stage_EX_stall = 1'b1;
        w3.barrier_MEM_WB_reset = 1'b1; w3.barrier_MEM_WB_stall = 1'b1;
        req[3] = w3;
        #1;
        e = '0; e.active = 1'b1; e.stage_EX_stall = 1'b1; e.barrier_MEM_WB_reset = 1'b1;
        check_eq("rst_merge", 32'(out), 32'(e));
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_onehot", 32'(onehot), 32'd0);
        check_eq("rst_timeout", 32'(tmo), 32'd0);
        check_eq("rst_count", cnt, 32'd0);
        check_eq("rst_conflict", 32'(conf), 32'd0);
        clr_req();
        #9;
        rst_n = 1'b1;

        // Non-exclusive OR-merge with reset-over-stall dominance
        next_cycle();
        w1 = '0; w1.active = 1'b1; w1.barrier_IF_ID_reset = 1'b1;
        w2 = '0; w2.active = 1'b1; w2.stage_IF_stall = 1'b1; w2.barrier_IF_ID_stall = 1'b1;
        req[1] = w1; req[2] = w2;
        sample();
        e = '0; e.active = 1'b1; e.barrier_IF_ID_reset = 1'b1; e.stage_IF_stall = 1'b1;
        check_eq("merge_out", 32'(out), 32'(e));
        check_eq("merge_locked", 32'(locked), 32'd0);
        next_cycle();
        clr_req();
        sample();
        check_eq("merge_locked_next", 32'(locked), 32'd0);
        check_eq("merge_count", cnt, 32'd1);

        // Exclusive lock by req[2] while req[0] asks for EX_MEM reset
        w2 = '0; w2.active = 1'b1; w2.exclusive = 1'b1; w2.stage_ID_stall = 1'b1;
        w0 = '0; w0.active = 1'b1; w0.barrier_EX_MEM_reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            req[2] = w2; req[0] = w0;
            sample();
            check_eq("lock2_out", 32'(out), 32'(w2));
            check_eq("lock2_locked", 32'(locked), (k > 1) ? 32'd1 : 32'd0);
            if (k > 1) check_eq("lock2_onehot", 32'(onehot), 32'b0100);
        end
        next_cycle();
        req[2] = '0;
        sample();
        check_eq("release_out", 32'(out), 32'(w0));
        check_eq("release_locked", 32'(locked), 32'd1);
        next_cycle();
        sample();
        check_eq("idle_out", 32'(out), 32'(w0));
        check_eq("idle_locked", 32'(locked), 32'd0);
        check_eq("lock2_count", cnt, 32'd6);
        next_cycle();
        clr_req();

        // Two exclusive requests: lowest index wins, conflict flagged
        w1 = '0; w1.active = 1'b1; w1.exclusive = 1'b1; w1.stage_MEM_stall = 1'b1;
        w3 = '0; w3.active = 1'b1; w3.exclusive = 1'b1; w3.stage_WB_stall = 1'b1;
        next_cycle();
        req[1] = w1; req[3] = w3;
        sample();
        check_eq("conf_flag", 32'(conf), 32'd1);
        check_eq("conf_out", 32'(out), 32'(w1));
        next_cycle();
        sample();
        check_eq("conf_onehot", 32'(onehot), 32'b0010);
        check_eq("conf_locked", 32'(locked), 32'd1);
        check_eq("conf_flag_locked", 32'(conf), 32'd0);
        check_eq("conf_hold_out", 32'(out), 32'(w1));
        next_cycle();
        clr_req();
        sample();
        check_eq("conf_release_out", 32'(out), 32'd0);
        check_eq("conf_count", cnt, 32'd8);

        // Release and new exclusive request in the same cycle
        w1 = '0; w1.active = 1'b1; w1.exclusive = 1'b1; w1.force_sr1_load = 1'b1;
        w3 = '0; w3.active = 1'b1; w3.exclusive = 1'b1; w3.force_sr2_load = 1'b1;
        next_cycle();
        req[1] = w1;
        sample();
        check_eq("hand_grant_out", 32'(out), 32'(w1));
        next_cycle();
        sample();
        check_eq("hand_locked", 32'(locked), 32'd1);
        next_cycle();
        req[1] = '0; req[3] = w3;
        sample();
        e = w3; e.exclusive = 1'b0;
        check_eq("hand_release_out", 32'(out), 32'(e));
        next_cycle();
        sample();
        check_eq("hand_regrant_out", 32'(out), 32'(w3));
        check_eq("hand_regrant_locked", 32'(locked), 32'd0);
        next_cycle();
        sample();
        check_eq("hand_onehot", 32'(onehot), 32'b1000);
        check_eq("hand_locked2", 32'(locked), 32'd1);
        next_cycle();
        clr_req();
        next_cycle();

        // Watchdog: req[0] exclusive for 70 cycles
        w0 = '0; w0.active = 1'b1; w0.exclusive = 1'b1; w0.stage_EX_stall = 1'b1;
        e = w0; e.exclusive = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            next_cycle();
            req[0] = w0;
            sample();
            check_eq("wd_out", 32'(out), (k <= 64) ? 32'(w0) : 32'(e));
            if (k == 2) check_eq("wd_locked", 32'(locked), 32'd1);
            if (k >= 63 && k <= 65) check_eq("wd_timeout", 32'(tmo), (k == 64) ? 32'd1 : 32'd0);
            if (k == 64) check_eq("wd_locked_last", 32'(locked), 32'd1);
            if (k == 65) begin
                check_eq("wd_unlocked", 32'(locked), 32'd0);
                check_eq("wd_conflict", 32'(conf), 32'd0);
            end
        end
        next_cycle();
        req[0] = '0;
        sample();
        check_eq("wd_count", cnt, 32'd78);
        next_cycle();
        req[0] = w0;
        sample();
        check_eq("wd_mask_cleared", 32'(out), 32'(w0));
        next_cycle();
        sample();
        check_eq("wd_relock", 32'(locked), 32'd1);
        check_eq("wd_relock_onehot", 32'(onehot), 32'b0001);

        // Asynchronous reset mid-lock
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_locked", 32'(locked), 32'd0);
        check_eq("arst_onehot", 32'(onehot), 32'd0);
        check_eq("arst_count", cnt, 32'd0);
        check_eq("arst_timeout", 32'(tmo), 32'd0);
        check_eq("arst_out", 32'(out), 32'(w0));
        check_eq("arst_sat_preload", cnt_s, 32'hFFFF_FFF0);
        @(posedge clk);
        #1;
        clr_req();
        #2;
        rst_n = 1'b1;

        // Re-arbitration from IDLE after reset
        w2 = '0; w2.active = 1'b1; w2.exclusive = 1'b1; w2.stage_ID_stall = 1'b1;
        next_cycle();
        req[2] = w2;
        sample();
        check_eq("rearb_out", 32'(out), 32'(w2));
        check_eq("rearb_locked0", 32'(locked), 32'd0);
        next_cycle();
        sample();
        check_eq("rearb_locked", 32'(locked), 32'd1);
        check_eq("rearb_onehot", 32'(onehot), 32'b0100);
        next_cycle();
        clr_req();
        next_cycle();

        // Saturating stall counter on the preloaded instance
        check_eq("sat_start", cnt_s, 32'hFFFF_FFF0);
        w0 = '0; w0.active = 1'b1; w0.stage_WB_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            req_sat[0] = w0;
        end
        next_cycle();
        clr_sat();
        sample();
        check_eq("sat_plus10", cnt_s, 32'hFFFF_FFFA);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            req_sat[0] = w0;
        end
        next_cycle();
        clr_sat();
        sample();
        check_eq("sat_max", cnt_s, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req_sat[0] = w0;
        end
        next_cycle();
        clr_sat();
        sample();
        check_eq("sat_stick", cnt_s, 32'hFFFF_FFFF);
        check_eq("main_count_after_reset", cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
